uart_tx_arb: RTL and testbench
==============================

Name: uart_tx_arb

Overview:
- Packet-level round-robin arbiter that shares one UART transmit datapath between NUM_REQ byte-stream requesters.
- Sits in front of the serial TX shift register and drives its tx_data/tx_en pair; the shift register returns tx_cts (clear-to-send).
- Once granted, a requester owns the transmitter for a whole packet (through its last byte), so packets from different sources never interleave on the wire.

Parameters:
- NUM_REQ, 4, number of requesters (1..8).
- MAX_PKT, 64, maximum bytes per grant before forced release (1..255).

Ports:
- ser_clk_1x  in  1  serial bit clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  in  NUM_REQ  byte is final byte of its packet.
- req_ready  out  NUM_REQ  per-requester byte accepted this cycle.
- tx_cts  in  1  downstream transmitter can take a byte this cycle.
- tx_en  out  1  byte offered to transmitter.
- tx_data  out  8  byte offered to transmitter.
- grant  out  NUM_REQ  one-hot current owner; zero when idle.
- busy  out  1  arbiter holds a grant.
- trunc  out  1  one-cycle pulse: packet force-terminated at MAX_PKT.

Behaviour:
- Reset (async, immediate, also mid-packet):
  - State returns to IDLE; owner, rr_ptr and byte_cnt go to 0.
  - grant, busy and trunc go to 0. Since tx_en, tx_data and req_ready decode from state, they are also 0.
  - Any partially sent packet is abandoned; no byte is completed.
- States: IDLE, TAG (only with the optional feature), STREAM.
- IDLE:
  - If any req_valid is high, select the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Register owner=i and grant=1<<i, clear byte_cnt, and move to STREAM (or TAG).
  - Nothing is transferred in IDLE.
- STREAM (combinational pass-through from owner):
  - tx_en = req_valid[owner]; tx_data = req_data[owner].
  - req_ready[owner] = tx_cts; all other req_ready bits are 0.
- Transfer: occurs on a cycle with req_valid[owner] and tx_cts both high; this is the only event that advances byte_cnt.
- Packet end:
  - Condition: transfer with req_last[owner]=1, or transfer where byte_cnt==MAX_PKT-1.
  - Next state is IDLE; rr_ptr = owner+1, wrapping to 0 at NUM_REQ; grant clears on the next edge.
  - Forced end without last pulses trunc for one cycle.
- Latency:
  - req_valid rising in IDLE at cycle t gives grant at t+1; first transfer is possible at t+1.
  - There is exactly one idle cycle between consecutive packets.
- Owner drops req_valid mid-packet: grant is held indefinitely; tx_en stays low; there is no timeout.
- tx_cts low: req_ready stays low and the offered byte must be held stable by the requester (valid/data/last must not change until transfer).
- Simultaneous requests: only the requester chosen by the rotation is served; the others wait. Every requester with continuous valid is served within NUM_REQ packets.
- NUM_REQ=1: rr_ptr stays 0; the arbiter behaves as a packet-gap inserter.
- Widths:
  - byte_cnt is 8 bits and compares against MAX_PKT-1.
  - rr_ptr and owner are $clog2(NUM_REQ) bits; when NUM_REQ=1 they are held at 0.
- busy = (state != IDLE).

Optional Feature:
- Macro: UART_TX_ARB_TAG_EN.
- Defined:
  - After arbitration, state TAG drives tx_en=1 and tx_data = 8'h80 | owner, with req_ready all 0.
  - When tx_cts=1, the tag is consumed and the state moves to STREAM.
  - The tag does not count toward MAX_PKT. First payload transfer is at t+2 at the earliest.
- Not defined: the TAG state is absent and IDLE goes directly to STREAM.

Test Plan:
- Single packet, req 0, bytes 48 65 6C (last on 6C), tx_cts held 1 → grant=0001 at t+1; tx_data sequence 48, 65, 6C on consecutive cycles; busy falls one cycle after 6C; rr_ptr=1.
- All four requesters valid at once, 2-byte packets each, starting from reset → grant order 0001, 0010, 0100, 1000, 0001; one idle cycle between packets; no bytes interleaved.
- tx_cts toggling 1,0,0,1 during a 3-byte packet from req 2 → req_ready[2] mirrors tx_cts; exactly 3 transfers; data order preserved; other req_ready bits stay 0.
- Req 1 sends 70 bytes without last (MAX_PKT=64) → release after the 64th transfer; trunc pulses for one cycle; the next grant goes to a different requester if one is valid, otherwise back to req 1 for the remaining 6 bytes.
- rst_n asserted after the 2nd byte of a 5-byte packet → grant, busy, tx_en and req_ready drop to 0 immediately; after release, a new request from req 3 is granted first (rr_ptr=0 scan finds 3).
- With UART_TX_ARB_TAG_EN, req 2 sends single byte 41 with last → tx_data sequence 82 then 41; tag consumed only when tx_cts=1; byte_cnt=1 at the end.

Source files
------------

// File: rtl/uart_tx_arb.sv
// Packet-level round-robin arbiter sharing one UART TX datapath between NUM_REQ requesters.
// Optional: define UART_TX_ARB_TAG_EN to send a tag byte 8'h80|owner ahead of each packet.
`timescale 1ns/1ps
module uart_tx_arb #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned MAX_PKT = 64
) (
    input  logic                 ser_clk_1x,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic                 tx_cts,
    output logic                 tx_en,
    output logic [7:0]           tx_data,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 trunc
);
    localparam int unsigned OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TAG    = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t               r_state;
    logic [OW-1:0]        r_owner;
    logic [OW-1:0]        r_rr;
    logic [7:0]           r_cnt;
    logic [NUM_REQ-1:0]   r_grant;
    logic                 r_busy;
    logic                 r_trunc;

    logic [OW-1:0]        w_pick;
    logic [OW-1:0]        w_idx;
    logic                 w_any;
    logic                 w_own_valid;
    logic                 w_own_last;
    logic [7:0]           w_own_data;
    logic                 w_xfer;
    logic                 w_end;
    logic [OW-1:0]        w_next_rr;

    assign w_own_valid = req_valid[r_owner];
    assign w_own_last  = req_last[r_owner];
    assign w_own_data  = req_data[{r_owner, 3'b000} +: 8];
    assign w_xfer      = (r_state == STREAM) && w_own_valid && tx_cts;
    assign w_end       = w_xfer && (w_own_last || (r_cnt == 8'(MAX_PKT - 1)));
    assign w_next_rr   = (r_owner == OW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

    // First valid requester scanning upward from the rotation pointer.
    always_comb begin
        w_pick = '0;
        w_any  = 1'b0;
        w_idx  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_idx = OW'((32'(r_rr) + k) % NUM_REQ);
            if (!w_any && req_valid[w_idx]) begin
                w_any  = 1'b1;
                w_pick = w_idx;
            end
        end
    end

    always_comb begin
        tx_en     = 1'b0;
        tx_data   = '0;
        req_ready = '0;
        case (r_state)
            STREAM: begin
                tx_en              = w_own_valid;
                tx_data            = w_own_data;
                req_ready[r_owner] = tx_cts;
            end
`ifdef UART_TX_ARB_TAG_EN
            TAG: begin
                tx_en   = 1'b1;
                tx_data = 8'h80 | 8'(r_owner);
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge ser_clk_1x or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_rr    <= '0;
            r_cnt   <= '0;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_trunc <= 1'b0;
        end else begin
            r_trunc <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_owner <= w_pick;
                        r_grant <= NUM_REQ'(1) << w_pick;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
`ifdef UART_TX_ARB_TAG_EN
                        r_state <= TAG;
`else
                        r_state <= STREAM;
`endif
                    end
                end
`ifdef UART_TX_ARB_TAG_EN
                TAG: begin
                    if (tx_cts) r_state <= STREAM;
                end
`endif
                STREAM: begin
                    if (w_xfer) r_cnt <= r_cnt + 8'd1;
                    if (w_end) begin
                        r_state <= IDLE;
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_rr    <= w_next_rr;
                        r_trunc <= !w_own_last;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign grant = r_grant;
    assign busy  = r_busy;
    assign trunc = r_trunc;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: per-cycle reference model plus directed packet scenarios.
`timescale 1ns/1ps
module tb_uart_tx_arb;
    localparam int N    = 4;
    localparam int MAXP = 64;
`ifdef UART_TX_ARB_TAG_EN
    localparam bit TAG_EN = 1'b1;
`else
    localparam bit TAG_EN = 1'b0;
`endif
    localparam int GAP  = TAG_EN ? 3 : 2;
    localparam int LAT  = TAG_EN ? 2 : 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]  req_last = '0;
    logic [N-1:0]  req_ready;
    logic          tx_cts = 1'b1;
    logic          tx_en;
    logic [7:0]    tx_data;
    logic [N-1:0]  grant;
    logic          busy;
    logic          trunc;

    always #5 clk = ~clk;

    uart_tx_arb #(.NUM_REQ(N), .MAX_PKT(MAXP)) dut (
        .ser_clk_1x (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .tx_cts     (tx_cts),
        .tx_en      (tx_en),
        .tx_data    (tx_data),
        .grant      (grant),
        .busy       (busy),
        .trunc      (trunc)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Requester byte sources: {last, data} entries consumed on observed transfers.
    logic [8:0] mem [N][128];
    int         rd [N];
    int         wr [N];
    logic [N-1:0] xfer_seen = '0;
    logic       cts_pat [$];

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Reference model: who owns the link, rotation start, bytes sent in this grant.
    bit         m_busy, m_tag, m_trunc;
    logic [1:0] m_own;
    int         m_rr, m_cnt, m_idx;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_tag = 0; m_trunc = 0; m_own = 2'd0; m_rr = 0; m_cnt = 0;
        end else begin
            m_trunc = 0;
            if (!m_busy) begin
                for (int k = 0; k < N; k++) begin
                    m_idx = (m_rr + k) % N;
                    if (req_valid[2'(m_idx)]) begin
                        m_busy = 1; m_own = 2'(m_idx); m_cnt = 0; m_tag = TAG_EN;
                        break;
                    end
                end
            end else if (m_tag) begin
                if (tx_cts) m_tag = 0;
            end else if (req_valid[m_own] && tx_cts) begin
                m_cnt++;
                if (req_last[m_own] || m_cnt == MAXP) begin
                    m_busy  = 0;
                    m_rr    = (int'(m_own) + 1) % N;
                    m_trunc = !req_last[m_own];
                end
            end
        end
    end

    // Observed traffic on the transmitter side.
    logic [7:0] plog [$];
    int         pcyc [$];
    logic [7:0] tlog [$];
    logic [3:0] glog [$];
    logic [3:0] prev_grant = '0;
    int         n_trunc = 0;
    logic [7:0] elog [$];
    logic [3:0] eglog [$];

    always @(negedge clk) begin
        logic       s;
        logic [3:0] eg, er;
        logic       ee;
        logic [7:0] ed;
        if (rst_n) begin
            s  = m_busy && !m_tag;
            eg = m_busy ? (4'b0001 << m_own) : 4'b0000;
            ee = m_tag | (s & req_valid[m_own]);
            ed = m_tag ? (8'h80 | {6'b0, m_own}) : (s ? req_data[{m_own, 3'b000} +: 8] : 8'h00);
            er = (s && tx_cts) ? (4'b0001 << m_own) : 4'b0000;
            chk("grant",     32'(grant),     32'(eg));
            chk("busy",      32'(busy),      32'(m_busy));
            chk("trunc",     32'(trunc),     32'(m_trunc));
            chk("tx_en",     32'(tx_en),     32'(ee));
            chk("tx_data",   32'(tx_data),   32'(ed));
            chk("req_ready", 32'(req_ready), 32'(er));
            if (tx_en && tx_cts) begin
                if (|req_ready) begin plog.push_back(tx_data); pcyc.push_back(cyc); end
                else tlog.push_back(tx_data);
            end
            if (grant != prev_grant && grant != 4'b0000) glog.push_back(grant);
            prev_grant = grant;
            if (trunc) n_trunc++;
        end
        xfer_seen = req_valid & req_ready;
    end

    task automatic push(input int r, input logic [7:0] d, input logic last);
        mem[r][wr[r]] = {last, d};
        wr[r]++;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (rd[i] < wr[i]) begin
                req_valid[i]       = 1'b1;
                req_data[i*8 +: 8] = mem[i][rd[i]][7:0];
                req_last[i]        = mem[i][rd[i]][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
        tx_cts = (cts_pat.size() > 0) ? cts_pat.pop_front() : 1'b1;
    endtask

    task automatic step();
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) if (xfer_seen[i]) rd[i]++;
        drive();
    endtask

    function automatic bit pending();
        for (int i = 0; i < N; i++) if (rd[i] < wr[i]) return 1;
        return 0;
    endfunction

    task automatic clear_logs();
        plog.delete(); pcyc.delete(); tlog.delete(); glog.delete();
        elog.delete(); eglog.delete(); n_trunc = 0;
    endtask

    task automatic drain(input int budget);
        int c = 0;
        while ((pending() || m_busy) && c < budget) begin step(); c++; end
        if (c >= budget) begin
            n_checks++; n_errors++;
            $display("FAIL drain_timeout: still busy after %0d cycles, required idle", c);
        end
        step(); step();
    endtask

    // Asserted mid-cycle: outputs must clear without waiting for an edge.
    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin rd[i] = 0; wr[i] = 0; end
        cts_pat.delete();
        drive();
        #1;
        chk("rst_grant",     32'(grant),     32'h0);
        chk("rst_busy",      32'(busy),      32'h0);
        chk("rst_trunc",     32'(trunc),     32'h0);
        chk("rst_tx_en",     32'(tx_en),     32'h0);
        chk("rst_tx_data",   32'(tx_data),   32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic check_plog(input string name);
        chk({name, "_len"}, plog.size(), elog.size());
        for (int j = 0; j < elog.size() && j < plog.size(); j++)
            chk({name, "_byte"}, 32'(plog[j]), 32'(elog[j]));
    endtask

    task automatic check_glog(input string name);
        chk({name, "_len"}, glog.size(), eglog.size());
        for (int j = 0; j < eglog.size() && j < glog.size(); j++)
            chk({name, "_grant"}, 32'(glog[j]), 32'(eglog[j]));
    endtask

    initial begin
        int t0, c;
        for (int i = 0; i < N; i++) begin rd[i] = 0; wr[i] = 0; end
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Single 3-byte packet from requester 0.
        push(0, 8'h48, 0); push(0, 8'h65, 0); push(0, 8'h6C, 1);
        drive();
        t0 = cyc;
        drain(50);
        elog = '{8'h48, 8'h65, 8'h6C};
        check_plog("t1");
        eglog = '{4'b0001};
        check_glog("t1");
        chk("t1_latency", pcyc[0] - t0, LAT);
        chk("t1_back2back_a", pcyc[1] - pcyc[0], 1);
        chk("t1_back2back_b", pcyc[2] - pcyc[1], 1);
        chk("t1_rr", m_rr, 1);

        // Four requesters at once, plus a second packet from requester 0.
        do_reset();
        for (int i = 0; i < N; i++) begin
            push(i, 8'(i * 16), 0); push(i, 8'(i * 16 + 1), 1);
        end
        push(0, 8'h02, 0); push(0, 8'h03, 1);
        drive();
        drain(200);
        elog = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h02, 8'h03};
        check_plog("t2");
        eglog = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        check_glog("t2");
        for (int j = 1; j < pcyc.size(); j++)
            chk("t2_spacing", pcyc[j] - pcyc[j-1], (j % 2 == 1) ? 1 : GAP);
        chk("t2_rr", m_rr, 1);

        // tx_cts stalls during a packet from requester 2.
        clear_logs();
        push(2, 8'h21, 0); push(2, 8'h22, 0); push(2, 8'h23, 1);
        cts_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        drive();
        drain(50);
        elog = '{8'h21, 8'h22, 8'h23};
        check_plog("t3");
        eglog = '{4'b0100};
        check_glog("t3");
        chk("t3_rr", m_rr, 3);

        // 70 bytes without last from requester 1; requester 3 joins meanwhile.
        clear_logs();
        for (int k = 0; k < 70; k++) push(1, 8'(k), 0);
        drive();
        repeat (10) step();
        push(3, 8'h55, 1);
        drive();
        c = 0;
        while (plog.size() < 71 && c < 400) begin step(); c++; end
        if (c >= 400) begin
            n_checks++; n_errors++;
            $display("FAIL t4_timeout: %0d bytes seen, required 71", plog.size());
        end
        repeat (5) step();
        for (int k = 0; k < 64; k++) elog.push_back(8'(k));
        elog.push_back(8'h55);
        for (int k = 64; k < 70; k++) elog.push_back(8'(k));
        check_plog("t4");
        eglog = '{4'b0010, 4'b1000, 4'b0010};
        check_glog("t4");
        chk("t4_trunc_pulses", n_trunc, 1);
        if (pcyc.size() > 64) chk("t4_release_gap", pcyc[64] - pcyc[63], GAP);
        chk("t4_hold_grant", 32'(grant), 32'h2);
        chk("t4_hold_busy",  32'(busy),  32'h1);
        chk("t4_hold_tx_en", 32'(tx_en), 32'h0);
        chk("t4_cnt", m_cnt, 6);

        // Reset after the 2nd byte of a 5-byte packet.
        do_reset();
        push(0, 8'hE0, 0); push(0, 8'hE1, 0); push(0, 8'hE2, 0); push(0, 8'hE3, 0); push(0, 8'hE4, 1);
        drive();
        c = 0;
        while (plog.size() < 2 && c < 20) begin step(); c++; end
        elog = '{8'hE0, 8'hE1};
        check_plog("t5a");
        do_reset();
        push(3, 8'h33, 1);
        drive();
        drain(50);
        elog = '{8'h33};
        check_plog("t5b");
        eglog = '{4'b1000};
        check_glog("t5b");
        chk("t5_rr", m_rr, 0);

        // Single byte from requester 2 with a stalled first cycle after grant.
        clear_logs();
        push(2, 8'h41, 1);
        cts_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        drive();
        drain(50);
        elog = '{8'h41};
        check_plog("t6");
        chk("t6_tag_count", tlog.size(), TAG_EN ? 1 : 0);
        for (int j = 0; j < tlog.size(); j++) chk("t6_tag_byte", 32'(tlog[j]), 32'h82);
        chk("t6_cnt", m_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required finish before 200000ns");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1);
    end

endmodule
